// File: rtl/regwb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regwb_pkg
// Description : Shared constants and types for the register-bank writeback
//               arbiter (source indices, widths, holding-entry layout).
// Revision    : 1.0 - initial release
// ============================================================================
package regwb_pkg;

    // Writeback source indices
    localparam int SRC_ALU  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_LINK = 2;

    // Geometry
    localparam int NREQ     = 3;
    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int NREG     = 1 << AW;
    localparam int LINK_REG = 31;

    // One buffered writeback per source
    typedef struct packed {
        logic          held;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    // One-hot register mask for a destination address
    function automatic logic [NREG-1:0] f_reg_bit(input logic [AW-1:0] addr);
        f_reg_bit = NREG'(1) << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regwb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regwb_arbiter_if
// Description : Bundle of writeback request lanes, bank write port and
//               hazard-check signals. The slave modport is the arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface regwb_arbiter_if
    import regwb_pkg::*;
();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;

    logic               regwrite;
    logic [AW-1:0]      write_reg;
    logic [DW-1:0]      write_data;

    logic [AW-1:0]      chk_reg_1;
    logic [AW-1:0]      chk_reg_2;
    logic               hazard_1;
    logic               hazard_2;
    logic [NREG-1:0]    pending;

    // Writeback sources and decode drive requests and read the results
    modport master (
        output req_valid, req_addr, req_data, chk_reg_1, chk_reg_2,
        input  req_ready, regwrite, write_reg, write_data,
               hazard_1, hazard_2, pending
    );

    // The arbiter itself
    modport slave (
        input  req_valid, req_addr, req_data, chk_reg_1, chk_reg_2,
        output req_ready, regwrite, write_reg, write_data,
               hazard_1, hazard_2, pending
    );

endinterface
`default_nettype wire

// File: rtl/regwb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : N-way round-robin arbiter. Search begins one past the last
//               granted index; at most one one-hot grant per cycle. The
//               last-grant pointer only moves when something is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [N-1:0] req,
    output logic      [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_last;
    logic [PW-1:0] w_next;
    logic [PW-1:0] w_sel;
    logic          w_found;
    int            w_pos;

    // Pick the first requester at or after last+1, wrapping modulo N
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_next  = r_last;
        w_pos   = 0;
        w_sel   = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = int'(r_last) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_sel = PW'(w_pos);
            if (!w_found && req[w_sel]) begin
                w_found      = 1'b1;
                grant[w_sel] = 1'b1;
                w_next       = w_sel;
            end
        end
    end

    // Last-grant pointer; reset so that index 0 has first priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PW'(N - 1);
        end else if (w_found) begin
            r_last <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regwb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regwb_arbiter
// Description : Writeback arbiter and pending-write scoreboard for the 32x32
//               register bank. One holding entry per source, round-robin onto
//               a single registered write port, RAW hazard lookup for two
//               read addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module regwb_arbiter
    import regwb_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    regwb_arbiter_if.slave  bus
);

    entry_t          r_entry [NREQ];
    logic [NREQ-1:0] w_held;
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_ready;
    logic [NREQ-1:0] w_accept;

    logic [AW-1:0]   w_gnt_addr;
    logic [DW-1:0]   w_gnt_data;

    logic            r_regwrite;
    logic [AW-1:0]   r_write_reg;
    logic [DW-1:0]   r_write_data;

    logic [NREG-1:0] w_pending;

    // Per-source handshake: an entry being drained this cycle can be refilled
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
            assign w_held[gi]   = r_entry[gi].held;
            assign w_ready[gi]  = !r_entry[gi].held | w_grant[gi];
            assign w_accept[gi] = bus.req_valid[gi] & w_ready[gi];
        end
    endgenerate

    rr_arbiter #(
        .N     (NREQ)
    ) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (w_held),
        .grant (w_grant)
    );

    // Holding entries: accept loads (even over a draining entry), grant clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_accept[i]) begin
                    r_entry[i].held <= 1'b1;
                    r_entry[i].addr <= bus.req_addr[i*AW +: AW];
                    r_entry[i].data <= bus.req_data[i*DW +: DW];
                end else if (w_grant[i]) begin
                    r_entry[i].held <= 1'b0;
                end
            end
        end
    end

    // Select the granted entry's address and data (grant is one-hot)
    always_comb begin
        w_gnt_addr = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_addr = w_gnt_addr | r_entry[i].addr;
                w_gnt_data = w_gnt_data | r_entry[i].data;
            end
        end
    end

    // Output stage: writes to r0 complete the handshake but never reach the bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite   <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (|w_grant) begin
            r_regwrite   <= (w_gnt_addr != '0);
            r_write_reg  <= w_gnt_addr;
            r_write_data <= w_gnt_data;
        end else begin
            r_regwrite   <= 1'b0;
        end
    end

    // Scoreboard: a register is pending while buffered or on the write port
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_entry[i].held) begin
                w_pending = w_pending | f_reg_bit(r_entry[i].addr);
            end
        end
        if (r_regwrite) begin
            w_pending = w_pending | f_reg_bit(r_write_reg);
        end
        w_pending[0] = 1'b0;
    end

    assign bus.req_ready  = w_ready;
    assign bus.regwrite   = r_regwrite;
    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;
    assign bus.pending    = w_pending;
    assign bus.hazard_1   = w_pending[bus.chk_reg_1];
    assign bus.hazard_2   = w_pending[bus.chk_reg_2];

endmodule
`default_nettype wire

// File: tb/tb_regwb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regwb_arbiter
// Description : Self-checking bench for regwb_arbiter: directed vector table
//               plus hand-written round-robin and mid-operation reset runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regwb_arbiter;
    import regwb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    regwb_arbiter_if bus ();

    regwb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [4:0]  c1, c2;
        logic [2:0]  e_ready;
        logic        e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [31:0] e_pend;
        logic        e_h1, e_h2;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit rst, input logic [2:0] v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [4:0] c1, input logic [4:0] c2,
                       input logic [2:0] er, input logic ew, input logic [4:0] ewr,
                       input logic [31:0] ewd, input logic [31:0] ep,
                       input logic eh1, input logic eh2);
        vec_t t;
        t.rst = rst; t.valid = v; t.a0 = a0; t.a1 = a1; t.a2 = a2;
        t.d0 = d0; t.d1 = d1; t.d2 = d2; t.c1 = c1; t.c2 = c2;
        t.e_ready = er; t.e_we = ew; t.e_wr = ewr; t.e_wd = ewd;
        t.e_pend = ep; t.e_h1 = eh1; t.e_h2 = eh2;
        vq.push_back(t);
    endtask

    task automatic set_req(input int src, input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.req_valid[src]          = v;
        bus.req_addr[src*AW +: AW]  = a;
        bus.req_data[src*DW +: DW]  = d;
    endtask

    // Leaves the bench at a falling edge with reset just released
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.chk_reg_1 = '0;
        bus.chk_reg_2 = '0;

        // Reset state
        #12;
        chk("rst_regwrite", 32'(bus.regwrite), 32'd0);
        chk("rst_write_reg", 32'(bus.write_reg), 32'd0);
        chk("rst_write_data", bus.write_data, 32'd0);
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'h7);

        // Uncontended ALU write r5=15
        add(1, 3'b001, 5, 0, 0, 15, 0, 0, 5, 0, 3'b111, 0, 0, 0, 32'h0, 0, 0);
        add(0, 3'b000, 5, 0, 0, 15, 0, 0, 5, 0, 3'b111, 0, 0, 0, 32'h20, 1, 0);
        add(0, 3'b000, 5, 0, 0, 15, 0, 0, 5, 0, 3'b111, 1, 5, 15, 32'h20, 1, 0);
        add(0, 3'b000, 5, 0, 0, 15, 0, 0, 5, 0, 3'b111, 0, 5, 15, 32'h0, 0, 0);
        // All three sources at once: ALU r3, LOAD r4, LINK r31
        add(1, 3'b111, 3, 4, LINK_REG, 32'hA, 32'hB, 32'hC, 3, LINK_REG, 3'b111, 0, 0, 0, 32'h0, 0, 0);
        add(0, 3'b000, 3, 4, LINK_REG, 32'hA, 32'hB, 32'hC, 3, LINK_REG, 3'b001, 0, 0, 0, 32'h8000_0018, 1, 1);
        add(0, 3'b000, 3, 4, LINK_REG, 32'hA, 32'hB, 32'hC, 3, LINK_REG, 3'b011, 1, 3, 32'hA, 32'h8000_0018, 1, 1);
        add(0, 3'b000, 3, 4, LINK_REG, 32'hA, 32'hB, 32'hC, 3, LINK_REG, 3'b111, 1, 4, 32'hB, 32'h8000_0010, 0, 1);
        add(0, 3'b000, 3, 4, LINK_REG, 32'hA, 32'hB, 32'hC, 3, LINK_REG, 3'b111, 1, 31, 32'hC, 32'h8000_0000, 0, 1);
        add(0, 3'b000, 3, 4, LINK_REG, 32'hA, 32'hB, 32'hC, 3, LINK_REG, 3'b111, 0, 31, 32'hC, 32'h0, 0, 0);
        // LOAD write to r0 is accepted and dropped
        add(0, 3'b010, 0, 0, 0, 0, 32'hDEAD, 0, 0, 5, 3'b111, 0, 31, 32'hC, 32'h0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 32'hDEAD, 0, 0, 5, 3'b111, 0, 31, 32'hC, 32'h0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 32'hDEAD, 0, 0, 5, 3'b111, 0, 0, 32'hDEAD, 32'h0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 32'hDEAD, 0, 0, 5, 3'b111, 0, 0, 32'hDEAD, 32'h0, 0, 0);

        foreach (vq[k]) begin
            if (vq[k].rst) do_reset();
            else @(negedge clk);
            set_req(SRC_ALU,  vq[k].valid[0], vq[k].a0, vq[k].d0);
            set_req(SRC_LOAD, vq[k].valid[1], vq[k].a1, vq[k].d1);
            set_req(SRC_LINK, vq[k].valid[2], vq[k].a2, vq[k].d2);
            bus.chk_reg_1 = vq[k].c1;
            bus.chk_reg_2 = vq[k].c2;
            #1;
            chk($sformatf("v%0d_ready", k), 32'(bus.req_ready), 32'(vq[k].e_ready));
            chk($sformatf("v%0d_regwrite", k), 32'(bus.regwrite), 32'(vq[k].e_we));
            chk($sformatf("v%0d_write_reg", k), 32'(bus.write_reg), 32'(vq[k].e_wr));
            chk($sformatf("v%0d_write_data", k), bus.write_data, vq[k].e_wd);
            chk($sformatf("v%0d_pending", k), bus.pending, vq[k].e_pend);
            chk($sformatf("v%0d_hazard_1", k), 32'(bus.hazard_1), 32'(vq[k].e_h1));
            chk($sformatf("v%0d_hazard_2", k), 32'(bus.hazard_2), 32'(vq[k].e_h2));
            @(posedge clk);
        end

        // Round-robin between ALU and LOAD with back-to-back refills
        begin
            int sent [2];
            int nwr, first_cyc, last_cyc;
            bit acc [2];
            sent[0] = 0; sent[1] = 0;
            nwr = 0; first_cyc = -1; last_cyc = -1;
            do_reset();
            for (int cyc = 0; cyc < 60 && nwr < 20; cyc++) begin
                if (cyc > 0) @(negedge clk);
                set_req(SRC_ALU,  sent[0] < 10, 5'(1 + sent[0]),  32'h0000_0100 + 32'(sent[0]));
                set_req(SRC_LOAD, sent[1] < 10, 5'(11 + sent[1]), 32'h0001_0100 + 32'(sent[1]));
                set_req(SRC_LINK, 1'b0, 5'd0, 32'd0);
                #1;
                if (bus.regwrite) begin
                    if (nwr < 20) begin
                        int src, idx;
                        src = nwr % 2;
                        idx = nwr / 2;
                        chk($sformatf("rr%0d_reg", nwr), 32'(bus.write_reg),
                            (src == 0) ? 32'(1 + idx) : 32'(11 + idx));
                        chk($sformatf("rr%0d_data", nwr), bus.write_data,
                            (src == 0) ? 32'h0000_0100 + 32'(idx) : 32'h0001_0100 + 32'(idx));
                    end
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    nwr++;
                end
                for (int i = 0; i < 2; i++) begin
                    acc[i] = bus.req_valid[i] & bus.req_ready[i];
                    if (acc[i]) begin
                        chk("rr_raw_clear", 32'(bus.pending[bus.req_addr[i*AW +: AW]]), 32'd0);
                    end
                end
                @(posedge clk);
                for (int i = 0; i < 2; i++) if (acc[i]) sent[i]++;
            end
            @(negedge clk);
            #1;
            chk("rr_count", 32'(nwr), 32'd20);
            chk("rr_span", 32'(last_cyc - first_cyc + 1), 32'd20);
            chk("rr_sent", 32'(sent[0] + sent[1]), 32'd20);
            chk("rr_idle", 32'(bus.regwrite), 32'd0);
        end

        // Reset while two entries are held and the output stage is busy
        do_reset();
        set_req(SRC_ALU,  1'b1, 5'd6, 32'h66);
        set_req(SRC_LOAD, 1'b1, 5'd7, 32'h77);
        set_req(SRC_LINK, 1'b1, 5'd8, 32'h88);
        bus.chk_reg_1 = 5'd7;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mr_pre_regwrite", 32'(bus.regwrite), 32'd1);
        chk("mr_pre_pending", bus.pending, 32'h0000_01C0);
        chk("mr_pre_hazard", 32'(bus.hazard_1), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_regwrite", 32'(bus.regwrite), 32'd0);
        chk("mr_write_reg", 32'(bus.write_reg), 32'd0);
        chk("mr_write_data", bus.write_data, 32'd0);
        chk("mr_pending", bus.pending, 32'd0);
        chk("mr_hazard", 32'(bus.hazard_1), 32'd0);
        chk("mr_ready", 32'(bus.req_ready), 32'h7);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(SRC_ALU,  1'b1, 5'd10, 32'hA0);
        set_req(SRC_LOAD, 1'b1, 5'd9,  32'h90);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mr_first_we", 32'(bus.regwrite), 32'd1);
        chk("mr_first_reg", 32'(bus.write_reg), 32'd10);
        chk("mr_first_data", bus.write_data, 32'hA0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mr_second_reg", 32'(bus.write_reg), 32'd9);
        chk("mr_second_data", bus.write_data, 32'h90);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
